// File: rtl/sub_bytes_pkg.sv
// Shared AES datapath types for the SubBytes stage.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTES   = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [7:0]             aes_byte_t;

    // Output register contents: the valid flag and the substituted state
    // travel together so they are always updated on the same edge.
    typedef struct packed {
        logic       valid;
        aes_state_t state;
    } sub_out_t;

endpackage : aes_pkg

// File: rtl/sub_bytes_if.sv
// Streaming bus for one 128-bit AES state per cycle, no backpressure.
interface sub_bytes_if;
    import aes_pkg::*;

    logic       in_valid;
    aes_state_t state_in;
    logic       out_valid;
    aes_state_t state_out;

    // Producer side: drives the input state and observes the result.
    modport master (
        output in_valid,
        output state_in,
        input  out_valid,
        input  state_out
    );

    // SubBytes stage side: consumes the input state and returns the result.
    modport slave (
        input  in_valid,
        input  state_in,
        output out_valid,
        output state_out
    );

endinterface : sub_bytes_if

// File: rtl/sub_bytes_sbox.sv
// Forward AES S-box as a fixed 256-entry lookup, purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t byte_i,
    output aes_byte_t byte_o
);

    aes_byte_t sboxVal;

    // Constant table lookup; every input value has an explicit entry.
    always_comb begin
        sboxVal = 8'h00;
        case (byte_i)
            8'h00: sboxVal = 8'h63; 8'h01: sboxVal = 8'h7c; 8'h02: sboxVal = 8'h77; 8'h03: sboxVal = 8'h7b; 8'h04: sboxVal = 8'hf2; 8'h05: sboxVal = 8'h6b; 8'h06: sboxVal = 8'h6f; 8'h07: sboxVal = 8'hc5;
            8'h08: sboxVal = 8'h30; 8'h09: sboxVal = 8'h01; 8'h0a: sboxVal = 8'h67; 8'h0b: sboxVal = 8'h2b; 8'h0c: sboxVal = 8'hfe; 8'h0d: sboxVal = 8'hd7; 8'h0e: sboxVal = 8'hab; 8'h0f: sboxVal = 8'h76;
            8'h10: sboxVal = 8'hca; 8'h11: sboxVal = 8'h82; 8'h12: sboxVal = 8'hc9; 8'h13: sboxVal = 8'h7d; 8'h14: sboxVal = 8'hfa; 8'h15: sboxVal = 8'h59; 8'h16: sboxVal = 8'h47; 8'h17: sboxVal = 8'hf0;
            8'h18: sboxVal = 8'had; 8'h19: sboxVal = 8'hd4; 8'h1a: sboxVal = 8'ha2; 8'h1b: sboxVal = 8'haf; 8'h1c: sboxVal = 8'h9c; 8'h1d: sboxVal = 8'ha4; 8'h1e: sboxVal = 8'h72; 8'h1f: sboxVal = 8'hc0;
            8'h20: sboxVal = 8'hb7; 8'h21: sboxVal = 8'hfd; 8'h22: sboxVal = 8'h93; 8'h23: sboxVal = 8'h26; 8'h24: sboxVal = 8'h36; 8'h25: sboxVal = 8'h3f; 8'h26: sboxVal = 8'hf7; 8'h27: sboxVal = 8'hcc;
            8'h28: sboxVal = 8'h34; 8'h29: sboxVal = 8'ha5; 8'h2a: sboxVal = 8'he5; 8'h2b: sboxVal = 8'hf1; 8'h2c: sboxVal = 8'h71; 8'h2d: sboxVal = 8'hd8; 8'h2e: sboxVal = 8'h31; 8'h2f: sboxVal = 8'h15;
            8'h30: sboxVal = 8'h04; 8'h31: sboxVal = 8'hc7; 8'h32: sboxVal = 8'h23; 8'h33: sboxVal = 8'hc3; 8'h34: sboxVal = 8'h18; 8'h35: sboxVal = 8'h96; 8'h36: sboxVal = 8'h05; 8'h37: sboxVal = 8'h9a;
            8'h38: sboxVal = 8'h07; 8'h39: sboxVal = 8'h12; 8'h3a: sboxVal = 8'h80; 8'h3b: sboxVal = 8'he2; 8'h3c: sboxVal = 8'heb; 8'h3d: sboxVal = 8'h27; 8'h3e: sboxVal = 8'hb2; 8'h3f: sboxVal = 8'h75;
            8'h40: sboxVal = 8'h09; 8'h41: sboxVal = 8'h83; 8'h42: sboxVal = 8'h2c; 8'h43: sboxVal = 8'h1a; 8'h44: sboxVal = 8'h1b; 8'h45: sboxVal = 8'h6e; 8'h46: sboxVal = 8'h5a; 8'h47: sboxVal = 8'ha0;
            8'h48: sboxVal = 8'h52; 8'h49: sboxVal = 8'h3b; 8'h4a: sboxVal = 8'hd6; 8'h4b: sboxVal = 8'hb3; 8'h4c: sboxVal = 8'h29; 8'h4d: sboxVal = 8'he3; 8'h4e: sboxVal = 8'h2f; 8'h4f: sboxVal = 8'h84;
            8'h50: sboxVal = 8'h53; 8'h51: sboxVal = 8'hd1; 8'h52: sboxVal = 8'h00; 8'h53: sboxVal = 8'hed; 8'h54: sboxVal = 8'h20; 8'h55: sboxVal = 8'hfc; 8'h56: sboxVal = 8'hb1; 8'h57: sboxVal = 8'h5b;
            8'h58: sboxVal = 8'h6a; 8'h59: sboxVal = 8'hcb; 8'h5a: sboxVal = 8'hbe; 8'h5b: sboxVal = 8'h39; 8'h5c: sboxVal = 8'h4a; 8'h5d: sboxVal = 8'h4c; 8'h5e: sboxVal = 8'h58; 8'h5f: sboxVal = 8'hcf;
            8'h60: sboxVal = 8'hd0; 8'h61: sboxVal = 8'hef; 8'h62: sboxVal = 8'haa; 8'h63: sboxVal = 8'hfb; 8'h64: sboxVal = 8'h43; 8'h65: sboxVal = 8'h4d; 8'h66: sboxVal = 8'h33; 8'h67: sboxVal = 8'h85;
            8'h68: sboxVal = 8'h45; 8'h69: sboxVal = 8'hf9; 8'h6a: sboxVal = 8'h02; 8'h6b: sboxVal = 8'h7f; 8'h6c: sboxVal = 8'h50; 8'h6d: sboxVal = 8'h3c; 8'h6e: sboxVal = 8'h9f; 8'h6f: sboxVal = 8'ha8;
            8'h70: sboxVal = 8'h51; 8'h71: sboxVal = 8'ha3; 8'h72: sboxVal = 8'h40; 8'h73: sboxVal = 8'h8f; 8'h74: sboxVal = 8'h92; 8'h75: sboxVal = 8'h9d; 8'h76: sboxVal = 8'h38; 8'h77: sboxVal = 8'hf5;
            8'h78: sboxVal = 8'hbc; 8'h79: sboxVal = 8'hb6; 8'h7a: sboxVal = 8'hda; 8'h7b: sboxVal = 8'h21; 8'h7c: sboxVal = 8'h10; 8'h7d: sboxVal = 8'hff; 8'h7e: sboxVal = 8'hf3; 8'h7f: sboxVal = 8'hd2;
            8'h80: sboxVal = 8'hcd; 8'h81: sboxVal = 8'h0c; 8'h82: sboxVal = 8'h13; 8'h83: sboxVal = 8'hec; 8'h84: sboxVal = 8'h5f; 8'h85: sboxVal = 8'h97; 8'h86: sboxVal = 8'h44; 8'h87: sboxVal = 8'h17;
            8'h88: sboxVal = 8'hc4; 8'h89: sboxVal = 8'ha7; 8'h8a: sboxVal = 8'h7e; 8'h8b: sboxVal = 8'h3d; 8'h8c: sboxVal = 8'h64; 8'h8d: sboxVal = 8'h5d; 8'h8e: sboxVal = 8'h19; 8'h8f: sboxVal = 8'h73;
            8'h90: sboxVal = 8'h60; 8'h91: sboxVal = 8'h81; 8'h92: sboxVal = 8'h4f; 8'h93: sboxVal = 8'hdc; 8'h94: sboxVal = 8'h22; 8'h95: sboxVal = 8'h2a; 8'h96: sboxVal = 8'h90; 8'h97: sboxVal = 8'h88;
            8'h98: sboxVal = 8'h46; 8'h99: sboxVal = 8'hee; 8'h9a: sboxVal = 8'hb8; 8'h9b: sboxVal = 8'h14; 8'h9c: sboxVal = 8'hde; 8'h9d: sboxVal = 8'h5e; 8'h9e: sboxVal = 8'h0b; 8'h9f: sboxVal = 8'hdb;
            8'ha0: sboxVal = 8'he0; 8'ha1: sboxVal = 8'h32; 8'ha2: sboxVal = 8'h3a; 8'ha3: sboxVal = 8'h0a; 8'ha4: sboxVal = 8'h49; 8'ha5: sboxVal = 8'h06; 8'ha6: sboxVal = 8'h24; 8'ha7: sboxVal = 8'h5c;
            8'ha8: sboxVal = 8'hc2; 8'ha9: sboxVal = 8'hd3; 8'haa: sboxVal = 8'hac; 8'hab: sboxVal = 8'h62; 8'hac: sboxVal = 8'h91; 8'had: sboxVal = 8'h95; 8'hae: sboxVal = 8'he4; 8'haf: sboxVal = 8'h79;
            8'hb0: sboxVal = 8'he7; 8'hb1: sboxVal = 8'hc8; 8'hb2: sboxVal = 8'h37; 8'hb3: sboxVal = 8'h6d; 8'hb4: sboxVal = 8'h8d; 8'hb5: sboxVal = 8'hd5; 8'hb6: sboxVal = 8'h4e; 8'hb7: sboxVal = 8'ha9;
            8'hb8: sboxVal = 8'h6c; 8'hb9: sboxVal = 8'h56; 8'hba: sboxVal = 8'hf4; 8'hbb: sboxVal = 8'hea; 8'hbc: sboxVal = 8'h65; 8'hbd: sboxVal = 8'h7a; 8'hbe: sboxVal = 8'hae; 8'hbf: sboxVal = 8'h08;
            8'hc0: sboxVal = 8'hba; 8'hc1: sboxVal = 8'h78; 8'hc2: sboxVal = 8'h25; 8'hc3: sboxVal = 8'h2e; 8'hc4: sboxVal = 8'h1c; 8'hc5: sboxVal = 8'ha6; 8'hc6: sboxVal = 8'hb4; 8'hc7: sboxVal = 8'hc6;
            8'hc8: sboxVal = 8'he8; 8'hc9: sboxVal = 8'hdd; 8'hca: sboxVal = 8'h74; 8'hcb: sboxVal = 8'h1f; 8'hcc: sboxVal = 8'h4b; 8'hcd: sboxVal = 8'hbd; 8'hce: sboxVal = 8'h8b; 8'hcf: sboxVal = 8'h8a;
            8'hd0: sboxVal = 8'h70; 8'hd1: sboxVal = 8'h3e; 8'hd2: sboxVal = 8'hb5; 8'hd3: sboxVal = 8'h66; 8'hd4: sboxVal = 8'h48; 8'hd5: sboxVal = 8'h03; 8'hd6: sboxVal = 8'hf6; 8'hd7: sboxVal = 8'h0e;
            8'hd8: sboxVal = 8'h61; 8'hd9: sboxVal = 8'h35; 8'hda: sboxVal = 8'h57; 8'hdb: sboxVal = 8'hb9; 8'hdc: sboxVal = 8'h86; 8'hdd: sboxVal = 8'hc1; 8'hde: sboxVal = 8'h1d; 8'hdf: sboxVal = 8'h9e;
            8'he0: sboxVal = 8'he1; 8'he1: sboxVal = 8'hf8; 8'he2: sboxVal = 8'h98; 8'he3: sboxVal = 8'h11; 8'he4: sboxVal = 8'h69; 8'he5: sboxVal = 8'hd9; 8'he6: sboxVal = 8'h8e; 8'he7: sboxVal = 8'h94;
            8'he8: sboxVal = 8'h9b; 8'he9: sboxVal = 8'h1e; 8'hea: sboxVal = 8'h87; 8'heb: sboxVal = 8'he9; 8'hec: sboxVal = 8'hce; 8'hed: sboxVal = 8'h55; 8'hee: sboxVal = 8'h28; 8'hef: sboxVal = 8'hdf;
            8'hf0: sboxVal = 8'h8c; 8'hf1: sboxVal = 8'ha1; 8'hf2: sboxVal = 8'h89; 8'hf3: sboxVal = 8'h0d; 8'hf4: sboxVal = 8'hbf; 8'hf5: sboxVal = 8'he6; 8'hf6: sboxVal = 8'h42; 8'hf7: sboxVal = 8'h68;
            8'hf8: sboxVal = 8'h41; 8'hf9: sboxVal = 8'h99; 8'hfa: sboxVal = 8'h2d; 8'hfb: sboxVal = 8'h0f; 8'hfc: sboxVal = 8'hb0; 8'hfd: sboxVal = 8'h54; 8'hfe: sboxVal = 8'hbb; 8'hff: sboxVal = 8'h16;
            default: sboxVal = 8'h00;
        endcase
    end

    assign byte_o = sboxVal;

endmodule : aes_sbox

// File: rtl/sub_bytes.sv
// AES SubBytes stage: 16 parallel S-boxes followed by one register stage.
module sub_bytes
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    sub_bytes_if.slave bus
);

    aes_state_t subState;
    sub_out_t   out_q;
    sub_out_t   out_d;

    // Bytes are substituted in place so byte i of the input lands in byte i
    // of the output; no lane crosses into another.
    for (genvar i = 0; i < AES_BYTES; i++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_i (bus.state_in[8*i +: 8]),
            .byte_o (subState[8*i +: 8])
        );
    end

    // Capture a new substituted state only on valid input; otherwise the
    // previous state is held and only the valid flag drops.
    always_comb begin
        out_d.valid = bus.in_valid;
        out_d.state = bus.in_valid ? subState : out_q.state;
    end

    // Single output register; reset wins over an in-flight input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out_valid = out_q.valid;
    assign bus.state_out = out_q.state;

endmodule : sub_bytes

// File: tb/tb_sub_bytes.sv
// Directed bench for sub_bytes with a scoreboard and an arithmetic S-box model.
module tb_sub_bytes;
    import aes_pkg::*;

    logic clk;
    logic rst_n;

    sub_bytes_if bus ();

    sub_bytes dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passCount = 0;
    int          checkCount = 0;
    aes_state_t  expQueue[$];
    logic        expValid = 1'b0;
    aes_state_t  expHold = '0;
    aes_byte_t   modelTab[256];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t gfMul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p = 8'h00;
        aes_byte_t x = a;
        aes_byte_t y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic aes_byte_t rotl8(input aes_byte_t b, input int n);
        aes_byte_t r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Forward S-box from first principles: inverse (x^254) then affine map.
    function automatic aes_byte_t sboxModel(input aes_byte_t v);
        aes_byte_t inv = 8'h00;
        if (v != 8'h00) begin
            inv = v;
            for (int k = 0; k < 253; k++) inv = gfMul(inv, v);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic aes_state_t subModel(input aes_state_t s);
        aes_state_t r;
        for (int k = 0; k < AES_BYTES; k++) r[8*k +: 8] = modelTab[int'(s[8*k +: 8])];
        return r;
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic checkState(input string tag, input aes_state_t obs, input aes_state_t exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle's inputs and record what the DUT must show after the edge.
    task automatic applyStimulus(input logic rst, input logic v, input aes_state_t data,
                                 input aes_state_t exp);
        rst_n        = rst;
        bus.in_valid = v;
        bus.state_in = data;
        if (!rst) begin
            expQueue.delete();
            expValid = 1'b0;
            expHold  = '0;
        end else if (v) begin
            expQueue.push_back(exp);
            expValid = 1'b1;
        end else begin
            expValid = 1'b0;
        end
    endtask

    // Advance one edge and compare the registered outputs against the scoreboard.
    task automatic checkOutput(input string tag);
        @(posedge clk);
        #1;
        checkBit({tag, "_valid"}, bus.out_valid, expValid);
        if (expValid) begin
            if (expQueue.size() == 0) begin
                checkCount++;
                $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
            end else begin
                expHold = expQueue.pop_front();
                checkState({tag, "_state"}, bus.state_out, expHold);
            end
        end else begin
            checkState({tag, "_state"}, bus.state_out, expHold);
        end
    endtask

    function automatic aes_state_t randState();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aes_state_t v;
        for (int k = 0; k < 256; k++) modelTab[k] = sboxModel(aes_byte_t'(k));

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.state_in = '0;

        // Reset held two cycles while valid random data is offered.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, randState(), '0);
            checkOutput("reset");
        end

        // First vector: literal expected value, one cycle latency.
        applyStimulus(1'b1, 1'b1, 128'h00102030405060708090a0b0c0d0e0f0,
                      128'h63cab7040953d051cd60e0e7ba70e18c);
        checkOutput("vec0");

        // Back-to-back vectors with valid held high.
        applyStimulus(1'b1, 1'b1, 128'h89d810e8855ace682d1843d8cb128fe4,
                      128'ha761ca9b97be8b45d8ad1a611fc97369);
        checkOutput("b2b0");
        applyStimulus(1'b1, 1'b1, 128'h247240236966b3fa6ed2753288425b6c,
                      128'h36400926f9336d2d9fb59d23c42c3950);
        checkOutput("b2b1");
        applyStimulus(1'b1, 1'b1, 128'hcb02818c17d2af9c62aa64428bb25fd7,
                      128'h1f770c64f0b579deaaac432c3d37cf0e);
        checkOutput("b2b2");

        // Idle hold: valid drops, state holds despite changing input data.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b0, randState(), '0);
            checkOutput("idle");
        end

        // Anchor bytes across lanes, including MSB lane mapping.
        applyStimulus(1'b1, 1'b1, 128'h00_01_10_53_80_ff_00_00_00_00_00_00_00_00_00_ff,
                      128'h63_7c_ca_ed_cd_16_63_63_63_63_63_63_63_63_63_16);
        checkOutput("anchor");

        // Exhaustive S-box, every lane carrying the same byte.
        for (int k = 0; k < 256; k++) begin
            v = {16{aes_byte_t'(k)}};
            applyStimulus(1'b1, 1'b1, v, subModel(v));
            checkOutput("exh");
        end

        // Random states through the model.
        for (int k = 0; k < 8; k++) begin
            v = randState();
            applyStimulus(1'b1, 1'b1, v, subModel(v));
            checkOutput("rand");
        end

        // Reset mid-stream: valid input, then reset on the following edge.
        v = randState();
        applyStimulus(1'b1, 1'b1, v, subModel(v));
        checkOutput("pre_rst");
        applyStimulus(1'b0, 1'b1, randState(), '0);
        checkOutput("mid_rst");
        applyStimulus(1'b1, 1'b0, randState(), '0);
        checkOutput("post_rst");
        applyStimulus(1'b1, 1'b0, randState(), '0);
        checkOutput("post_rst2");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_sub_bytes
